// File: rtl/scaled_pixel_packer.sv
// RGB888 -> RGB565 packer: eight pixels per 128-bit word, tagged with a frame word
// address, buffered in a show-ahead FIFO and drained over valid/ready.

module scaled_pixel_packer_slot (
   input  logic        pixclk_in,
   input  logic        rst_n,
   input  logic        we,
   input  logic        clr,
   input  logic [15:0] d,
   output logic [15:0] q
);
   always_ff @(posedge pixclk_in or negedge rst_n)
      if (!rst_n)   q <= '0;
      else if (we)  q <= d;
      else if (clr) q <= '0;
endmodule

module scaled_pixel_packer #(
   parameter int PIXEL_DATA_WIDTH     = 24,
   parameter int OUT_DATA_WIDTH       = 128,
   parameter int DST_IMAGE_RES_WIDTH  = 320,
   parameter int DST_IMAGE_RES_HEIGHT = 360,
   parameter int FIFO_DEPTH           = 16
) (
   input  logic                        pixclk_in,
   input  logic                        rst_n,
   input  logic                        frame_start,
   input  logic                        de_in,
   input  logic [PIXEL_DATA_WIDTH-1:0] i_pixel,
   output logic [OUT_DATA_WIDTH-1:0]   m_data,
   output logic [15:0]                 m_addr,
   output logic                        m_eof,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic                        frame_done,
   output logic                        overflow
);
   localparam int NUM_LANES = OUT_DATA_WIDTH / 16;
   localparam int WPL       = (DST_IMAGE_RES_WIDTH + NUM_LANES - 1) / NUM_LANES;
   localparam int CW        = $clog2(DST_IMAGE_RES_WIDTH + 1);
   localparam int LW        = $clog2(DST_IMAGE_RES_HEIGHT);
   localparam int IW        = $clog2(WPL + 1);
   localparam int PW        = $clog2(NUM_LANES);
   localparam int AW        = $clog2(FIFO_DEPTH);
   localparam int EW        = OUT_DATA_WIDTH + 17;

   localparam logic [CW-1:0] LINE_PIX  = CW'(DST_IMAGE_RES_WIDTH);
   localparam logic [LW-1:0] LAST_LINE = LW'(DST_IMAGE_RES_HEIGHT - 1);
   localparam logic [IW-1:0] LAST_WORD = IW'(WPL - 1);
   localparam logic [PW-1:0] LAST_SLOT = PW'(NUM_LANES - 1);
   localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

   logic                           de_d;
   logic [PW-1:0]                  pix_cnt, pc_e;
   logic [CW-1:0]                  col_cnt, col_e;
   logic [LW-1:0]                  line_cnt, line_e;
   logic [IW-1:0]                  word_idx, idx_e;
   logic [15:0]                    px565;
   logic                           take, word_full, line_end, flush, slot_clr;
   logic [NUM_LANES-1:0]           slot_we;
   logic [NUM_LANES-1:0][15:0]     slot_q, word_w;
   logic [15:0]                    cur_addr;
   logic                           cur_eof;

   logic                           push_vld, push_eof;
   logic [OUT_DATA_WIDTH-1:0]      push_data;
   logic [15:0]                    push_addr;

   // frame_start zeroes the counters before the same-cycle pixel is placed
   assign pc_e      = frame_start ? '0 : pix_cnt;
   assign col_e     = frame_start ? '0 : col_cnt;
   assign line_e    = frame_start ? '0 : line_cnt;
   assign idx_e     = frame_start ? '0 : word_idx;
   assign px565     = {i_pixel[23:19], i_pixel[15:10], i_pixel[7:3]};
   assign take      = de_in && (col_e < LINE_PIX);
   assign word_full = take && (pc_e == LAST_SLOT);
   assign line_end  = de_d && !de_in && !frame_start && (col_cnt != '0);
   assign flush     = line_end && (pix_cnt != '0);
   assign slot_clr  = frame_start || word_full || line_end;
   assign cur_addr  = 16'(line_e) * 16'(WPL) + 16'(idx_e);
   assign cur_eof   = (line_e == LAST_LINE) && (idx_e == LAST_WORD);

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign slot_we[k] = take && !word_full && (pc_e == PW'(k));
      assign word_w[k]  = (take && pc_e == PW'(k)) ? px565 : slot_q[k];
   end

   scaled_pixel_packer_slot u_slot [NUM_LANES-1:0] (
      .pixclk_in (pixclk_in),
      .rst_n     (rst_n),
      .we        (slot_we),
      .clr       (slot_clr),
      .d         (px565),
      .q         (slot_q)
   );

   always_ff @(posedge pixclk_in or negedge rst_n) begin
      if (!rst_n) begin
         de_d      <= 1'b0;
         pix_cnt   <= '0;
         col_cnt   <= '0;
         line_cnt  <= '0;
         word_idx  <= '0;
         push_vld  <= 1'b0;
         push_data <= '0;
         push_addr <= '0;
         push_eof  <= 1'b0;
      end else begin
         de_d     <= de_in;
         push_vld <= word_full || flush;
         if (word_full || flush) begin
            push_data <= word_full ? word_w : slot_q;
            push_addr <= cur_addr;
            push_eof  <= cur_eof;
         end
         if (take) begin
            col_cnt  <= col_e + 1'b1;
            pix_cnt  <= pc_e + 1'b1;
            line_cnt <= line_e;
            word_idx <= word_full ? idx_e + 1'b1 : idx_e;
         end else if (line_end) begin
            line_cnt <= (line_cnt == LAST_LINE) ? line_cnt : line_cnt + 1'b1;
            col_cnt  <= '0;
            pix_cnt  <= '0;
            word_idx <= '0;
         end else begin
            col_cnt  <= col_e;
            pix_cnt  <= pc_e;
            line_cnt <= line_e;
            word_idx <= idx_e;
         end
      end
   end

   // output FIFO, show-ahead; a push into a full FIFO is accepted only alongside a pop
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic [EW-1:0] head;
   logic          pop, full, wr_en, drop;

   assign m_valid = (count != '0);
   assign full    = (count == FULL_CNT);
   assign pop     = m_valid && m_ready;
   assign wr_en   = push_vld && (!full || pop);
   assign drop    = push_vld && full && !pop;
   assign head    = mem[rd_ptr];
   assign m_data  = m_valid ? head[EW-1:17] : '0;
   assign m_addr  = m_valid ? head[16:1]    : '0;
   assign m_eof   = m_valid && head[0];

   always_ff @(posedge pixclk_in)
      if (wr_en) mem[wr_ptr] <= {push_data, push_addr, push_eof};

   always_ff @(posedge pixclk_in or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         overflow   <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (frame_start) overflow <= 1'b0;
         else if (drop)   overflow <= 1'b1;
         frame_done <= pop && m_eof;
      end
   end
endmodule
